// File: rtl/fifo_credit_arb.sv
// Credit-based round-robin arbiter feeding one FIFO write port; never writes without a credit.
// Optional packet lock (hold grant until req_last) is enabled by defining FIFO_CREDIT_ARB_PKT_LOCK_EN.
module fifo_credit_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3,
  parameter int REQ_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          credit_return,
  output logic [ADDR_W:0]               credits,
  output logic [REQ_W-1:0]              grant_id,
  output logic                          credit_err
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_a;
  logic [ADDR_W:0]   cred_q, cred_d;
  logic [REQ_W-1:0]  ptr_q, ptr_d, win, g, g_nxt;
  logic              err_q, err_d;
  logic              has_cred, xfer, grant_end;

  assign data_a   = req_data;
  assign has_cred = (cred_q != '0);

  // Lowest rotating offset from ptr wins; loop runs downward so it is assigned last.
  always_comb begin
    logic [REQ_W-1:0] idx;
    win = ptr_q;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = REQ_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) win = idx;
    end
  end

`ifdef FIFO_CREDIT_ARB_PKT_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           st_q, st_d;
  logic [REQ_W-1:0] lock_q, lock_d;

  assign g         = (st_q == LOCKED) ? lock_q : win;
  assign grant_end = xfer && req_last[g];

  always_comb begin
    st_d   = st_q;
    lock_d = lock_q;
    if (xfer) begin
      if (!req_last[g]) begin
        st_d   = LOCKED;
        lock_d = g;
      end else begin
        st_d = IDLE;
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign g           = win;
  assign grant_end   = xfer;
`endif

  assign g_nxt = (g == REQ_W'(NUM_REQ-1)) ? '0 : g + 1'b1;

  always_comb begin
    req_ready = '0;
    if (!rst) req_ready[g] = out_ready && has_cred;
  end

  assign out_valid  = req_valid[g] && has_cred && !rst;
  assign out_data   = rst ? '0 : data_a[g];
  assign grant_id   = rst ? '0 : g;
  assign xfer       = out_valid && out_ready;
  assign credits    = cred_q;
  assign credit_err = err_q;

  // A return while already full saturates and latches the error.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (xfer && !credit_return) begin
      cred_d = cred_q - 1'b1;
    end else if (credit_return && !xfer) begin
      if (cred_q == FULL) err_d = 1'b1;
      else                cred_d = cred_q + 1'b1;
    end
    ptr_d = grant_end ? g_nxt : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q <= FULL;
      ptr_q  <= '0;
      err_q  <= 1'b0;
`ifdef FIFO_CREDIT_ARB_PKT_LOCK_EN
      st_q   <= IDLE;
      lock_q <= '0;
`endif
    end else begin
      cred_q <= cred_d;
      ptr_q  <= ptr_d;
      err_q  <= err_d;
`ifdef FIFO_CREDIT_ARB_PKT_LOCK_EN
      st_q   <= st_d;
      lock_q <= lock_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_credit_arb.sv
// Scoreboard bench for fifo_credit_arb: stimulus pushes expected beats, a negedge monitor pops and checks them.
module tb_fifo_credit_arb;
  localparam int DW = 32;
  localparam int NR = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_last;
  logic [NR-1:0][DW-1:0] reqd;
  logic              out_valid, out_ready, credit_return, credit_err;
  logic [DW-1:0]     out_data;
  logic [3:0]        credits;
  logic [1:0]        grant_id;

  fifo_credit_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .DEPTH(8), .ADDR_W(3), .REQ_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(reqd),
    .req_last(req_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .credit_return(credit_return), .credits(credits), .grant_id(grant_id), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [3:0] cr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic done     = 1'b0;

  function automatic logic [DW-1:0] dval(int i);
    return 32'hD000_0000 + 32'(i) * 32'h0000_0111;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int id, int cr);
    exp_t e;
    e.id = 2'(id);
    e.cr = 4'(cr);
    q.push_back(e);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!done && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", {30'd0, grant_id}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("beat_grant_id", {30'd0, grant_id}, {30'd0, e.id});
        chk("beat_data", out_data, dval(int'(e.id)));
        chk("beat_credits", {28'd0, credits}, {28'd0, e.cr});
        chk("beat_req_ready", {28'd0, req_ready}, 32'(1) << e.id);
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) reqd[i] = dval(i);
    rst = 1'b1; req_valid = 4'b0010; req_last = 4'b1111; out_ready = 1'b1; credit_return = 1'b0;

    // Reset: outputs gated even with a request and ready present.
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_credits", {28'd0, credits}, 32'd8);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_credit_err", {31'd0, credit_err}, 32'd0);

    // Fill: 8 beats drain credits 8..1, then stall.
    rst = 1'b0; req_valid = 4'b0001;
    for (int k = 0; k < 8; k++) push(0, 8 - k);
    repeat (10) tick();
    chk("fill_credits", {28'd0, credits}, 32'd0);
    chk("fill_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fill_req_ready", {28'd0, req_ready}, 32'd0);

    // Credit recovery: one return gives exactly one more beat.
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("recov_credits_1", {28'd0, credits}, 32'd1);
    push(0, 1);
    tick();
    chk("recov_credits_0", {28'd0, credits}, 32'd0);
    tick();
    chk("recov_credits_hold", {28'd0, credits}, 32'd0);

    // Coincident transfer and return leave credits unchanged.
    req_valid = 4'b0000; credit_return = 1'b1;
    repeat (3) tick();
    chk("simul_pre", {28'd0, credits}, 32'd3);
    req_valid = 4'b0001;
    push(0, 3); push(0, 3);
    repeat (2) tick();
    chk("simul_credits", {28'd0, credits}, 32'd3);

    // Refill to full, then overflow sets sticky error.
    req_valid = 4'b0000;
    repeat (5) tick();
    chk("full_credits", {28'd0, credits}, 32'd8);
    chk("full_err", {31'd0, credit_err}, 32'd0);
    tick();
    credit_return = 1'b0;
    chk("ovf_credits", {28'd0, credits}, 32'd8);
    chk("ovf_err", {31'd0, credit_err}, 32'd1);
    repeat (3) tick();
    chk("ovf_err_sticky", {31'd0, credit_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_rst_err", {31'd0, credit_err}, 32'd0);
    chk("ovf_rst_credits", {28'd0, credits}, 32'd8);

    // Round robin with returns tied to each transfer.
    req_valid = 4'b1111; credit_return = 1'b1;
    push(0, 8); push(1, 8); push(2, 8); push(3, 8); push(0, 8); push(1, 8);
    repeat (6) tick();
    req_valid = 4'b0000; credit_return = 1'b0;
    chk("rr_credits", {28'd0, credits}, 32'd8);

    // Packet: requester 1 sends 3 beats (last on beat 3) while requester 2 is valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b0110;
`ifdef FIFO_CREDIT_ARB_PKT_LOCK_EN
    push(1, 8); push(1, 7); push(1, 6); push(2, 5);
`else
    push(1, 8); push(2, 7); push(1, 6); push(2, 5);
`endif
    for (int c = 0; c < 4; c++) begin
      req_last = {2'b11, (c >= 2), 1'b1};
      tick();
    end
    req_valid = 4'b0000; req_last = 4'b1111;
    chk("pkt_credits", {28'd0, credits}, 32'd4);

    // Mid-operation reset with credits=3 (FSM locked when packet lock is built in).
    req_valid = 4'b0010; req_last = 4'b1101;
    push(1, 4);
    tick();
    rst = 1'b1; req_valid = 4'b0000;
    chk("mid_pre_credits", {28'd0, credits}, 32'd3);
    tick();
    rst = 1'b0; req_last = 4'b1111;
    chk("mid_credits", {28'd0, credits}, 32'd8);
    chk("mid_grant_id", {30'd0, grant_id}, 32'd0);
    chk("mid_err", {31'd0, credit_err}, 32'd0);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0; req_valid = 4'b0100;
    #1;
    chk("mid_idle_grant", {30'd0, grant_id}, 32'd2);
    repeat (2) tick();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
